// File: rtl/iob_soc_opencryptolinux_axi2axil.sv
// AXI4 burst to AXI-Lite single-beat splitter with independent read and write paths.
// Define IOB_AXI2AXIL_WRAP_EN to honour WRAP bursts; otherwise WRAP behaves as INCR.
module iob_soc_opencryptolinux_axi2axil #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1,
    parameter int LEN_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic [ID_W-1:0]     s_axi_awid_i,
    input  logic [ADDR_W-1:0]   s_axi_awaddr_i,
    input  logic [LEN_W-1:0]    s_axi_awlen_i,
    input  logic [2:0]          s_axi_awsize_i,
    input  logic [1:0]          s_axi_awburst_i,
    input  logic                s_axi_awvalid_i,
    output logic                s_axi_awready_o,
    input  logic [DATA_W-1:0]   s_axi_wdata_i,
    input  logic [DATA_W/8-1:0] s_axi_wstrb_i,
    input  logic                s_axi_wlast_i,
    input  logic                s_axi_wvalid_i,
    output logic                s_axi_wready_o,
    output logic [ID_W-1:0]     s_axi_bid_o,
    output logic [1:0]          s_axi_bresp_o,
    output logic                s_axi_bvalid_o,
    input  logic                s_axi_bready_i,
    input  logic [ID_W-1:0]     s_axi_arid_i,
    input  logic [ADDR_W-1:0]   s_axi_araddr_i,
    input  logic [LEN_W-1:0]    s_axi_arlen_i,
    input  logic [2:0]          s_axi_arsize_i,
    input  logic [1:0]          s_axi_arburst_i,
    input  logic                s_axi_arvalid_i,
    output logic                s_axi_arready_o,
    output logic [ID_W-1:0]     s_axi_rid_o,
    output logic [DATA_W-1:0]   s_axi_rdata_o,
    output logic [1:0]          s_axi_rresp_o,
    output logic                s_axi_rlast_o,
    output logic                s_axi_rvalid_o,
    input  logic                s_axi_rready_i,
    output logic [ADDR_W-1:0]   m_axil_awaddr_o,
    output logic [2:0]          m_axil_awprot_o,
    output logic                m_axil_awvalid_o,
    input  logic                m_axil_awready_i,
    output logic [DATA_W-1:0]   m_axil_wdata_o,
    output logic [DATA_W/8-1:0] m_axil_wstrb_o,
    output logic                m_axil_wvalid_o,
    input  logic                m_axil_wready_i,
    input  logic [1:0]          m_axil_bresp_i,
    input  logic                m_axil_bvalid_i,
    output logic                m_axil_bready_o,
    output logic [ADDR_W-1:0]   m_axil_araddr_o,
    output logic [2:0]          m_axil_arprot_o,
    output logic                m_axil_arvalid_o,
    input  logic                m_axil_arready_i,
    input  logic [DATA_W-1:0]   m_axil_rdata_i,
    input  logic [1:0]          m_axil_rresp_i,
    input  logic                m_axil_rvalid_i,
    output logic                m_axil_rready_o
);
`ifdef IOB_AXI2AXIL_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_DATA, W_LITE, W_RESP, W_BRESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic [ID_W-1:0]     r_id, w_id;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [LEN_W-1:0]    r_len, w_len, r_cnt, w_cnt;
    logic [2:0]          r_size, w_size;
    logic [1:0]          r_burst, w_burst, acc_resp;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                aw_done, w_done, r_last, lite_done;
    logic                unused_wlast;

    // Beat count comes from awlen alone, so wlast carries no information here.
    assign unused_wlast = s_axi_wlast_i;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] sz,
                                                    input logic [LEN_W-1:0] ln,
                                                    input logic [1:0] bt);
        logic [ADDR_W-1:0] step, mask;
        step = ADDR_W'(1) << sz;
        mask = ((ADDR_W'(ln) + ADDR_W'(1)) << sz) - ADDR_W'(1);
        if (bt == 2'b00)
            next_addr = a;
        else if (WRAP_EN && bt == 2'b10)
            next_addr = (a & ~mask) | ((a + step) & mask);
        else
            next_addr = a + step;
    endfunction

    assign r_last          = (r_cnt == r_len);
    assign s_axi_rid_o     = r_id;
    assign s_axi_rdata_o   = m_axil_rdata_i;
    assign s_axi_rresp_o   = m_axil_rresp_i;
    assign s_axi_rlast_o   = (r_state == R_DATA) && r_last;
    assign m_axil_araddr_o = r_addr;
    assign m_axil_arprot_o = 3'b000;

    always_comb begin
        r_next           = r_state;
        s_axi_arready_o  = 1'b0;
        m_axil_arvalid_o = 1'b0;
        s_axi_rvalid_o   = 1'b0;
        m_axil_rready_o  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready_o = 1'b1;
                if (s_axi_arvalid_i) r_next = R_ADDR;
            end
            R_ADDR: begin
                m_axil_arvalid_o = 1'b1;
                if (m_axil_arready_i) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid_o  = m_axil_rvalid_i;
                m_axil_rready_o = s_axi_rready_i;
                if (m_axil_rvalid_i && s_axi_rready_i) r_next = r_last ? R_IDLE : R_ADDR;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else if (cke_i) begin
            r_state <= r_next;
            if (r_state == R_IDLE && s_axi_arvalid_i) begin
                r_id    <= s_axi_arid_i;
                r_addr  <= s_axi_araddr_i;
                r_len   <= s_axi_arlen_i;
                r_size  <= s_axi_arsize_i;
                r_burst <= s_axi_arburst_i;
                r_cnt   <= '0;
            end
            if (r_state == R_DATA && m_axil_rvalid_i && s_axi_rready_i && !r_last) begin
                r_cnt  <= r_cnt + 1'b1;
                r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
            end
        end
    end

    // Address and data channels of a Lite write may complete in either order.
    assign lite_done       = (aw_done || m_axil_awready_i) && (w_done || m_axil_wready_i);
    assign s_axi_bid_o     = w_id;
    assign s_axi_bresp_o   = acc_resp;
    assign m_axil_awaddr_o = w_addr;
    assign m_axil_awprot_o = 3'b000;
    assign m_axil_wdata_o  = w_data;
    assign m_axil_wstrb_o  = w_strb;

    always_comb begin
        w_next           = w_state;
        s_axi_awready_o  = 1'b0;
        s_axi_wready_o   = 1'b0;
        s_axi_bvalid_o   = 1'b0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready_o = 1'b1;
                if (s_axi_awvalid_i) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready_o = 1'b1;
                if (s_axi_wvalid_i) w_next = W_LITE;
            end
            W_LITE: begin
                m_axil_awvalid_o = !aw_done;
                m_axil_wvalid_o  = !w_done;
                if (lite_done) w_next = W_RESP;
            end
            W_RESP: begin
                m_axil_bready_o = 1'b1;
                if (m_axil_bvalid_i) w_next = (w_cnt == w_len) ? W_BRESP : W_DATA;
            end
            W_BRESP: begin
                s_axi_bvalid_o = 1'b1;
                if (s_axi_bready_i) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            acc_resp <= 2'b00;
        end else if (cke_i) begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: if (s_axi_awvalid_i) begin
                    w_id     <= s_axi_awid_i;
                    w_addr   <= s_axi_awaddr_i;
                    w_len    <= s_axi_awlen_i;
                    w_size   <= s_axi_awsize_i;
                    w_burst  <= s_axi_awburst_i;
                    w_cnt    <= '0;
                    acc_resp <= 2'b00;
                end
                W_DATA: if (s_axi_wvalid_i) begin
                    w_data <= s_axi_wdata_i;
                    w_strb <= s_axi_wstrb_i;
                end
                W_LITE: begin
                    aw_done <= lite_done ? 1'b0 : (aw_done || m_axil_awready_i);
                    w_done  <= lite_done ? 1'b0 : (w_done || m_axil_wready_i);
                end
                W_RESP: if (m_axil_bvalid_i) begin
                    if (m_axil_bresp_i > acc_resp) acc_resp <= m_axil_bresp_i;
                    if (w_cnt != w_len) begin
                        w_cnt  <= w_cnt + 1'b1;
                        w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_soc_opencryptolinux_axi2axil.sv
// Directed plus randomized bench for the AXI4 to AXI-Lite burst splitter.
module tb_iob_soc_opencryptolinux_axi2axil;
    logic        clk_i = 1'b0, rst_i, cke_i;
    logic [0:0]  s_axi_awid_i, s_axi_arid_i, s_axi_bid_o, s_axi_rid_o;
    logic [31:0] s_axi_awaddr_i, s_axi_araddr_i, s_axi_wdata_i, s_axi_rdata_o;
    logic [7:0]  s_axi_awlen_i, s_axi_arlen_i;
    logic [2:0]  s_axi_awsize_i, s_axi_arsize_i, m_axil_awprot_o, m_axil_arprot_o;
    logic [1:0]  s_axi_awburst_i, s_axi_arburst_i, s_axi_bresp_o, s_axi_rresp_o;
    logic [3:0]  s_axi_wstrb_i, m_axil_wstrb_o;
    logic        s_axi_awvalid_i, s_axi_awready_o, s_axi_wlast_i, s_axi_wvalid_i, s_axi_wready_o;
    logic        s_axi_bvalid_o, s_axi_bready_i, s_axi_arvalid_i, s_axi_arready_o;
    logic        s_axi_rlast_o, s_axi_rvalid_o, s_axi_rready_i;
    logic [31:0] m_axil_awaddr_o, m_axil_wdata_o, m_axil_araddr_o, m_axil_rdata_i;
    logic        m_axil_awvalid_o, m_axil_awready_i, m_axil_wvalid_o, m_axil_wready_i;
    logic [1:0]  m_axil_bresp_i, m_axil_rresp_i;
    logic        m_axil_bvalid_i, m_axil_bready_o, m_axil_arvalid_o, m_axil_arready_i;
    logic        m_axil_rvalid_i, m_axil_rready_o;

    int checks = 0;
    int failures = 0;

    iob_soc_opencryptolinux_axi2axil dut (
        .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i),
        .s_axi_awid_i(s_axi_awid_i), .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awlen_i(s_axi_awlen_i),
        .s_axi_awsize_i(s_axi_awsize_i), .s_axi_awburst_i(s_axi_awburst_i),
        .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_awready_o(s_axi_awready_o),
        .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i), .s_axi_wlast_i(s_axi_wlast_i),
        .s_axi_wvalid_i(s_axi_wvalid_i), .s_axi_wready_o(s_axi_wready_o),
        .s_axi_bid_o(s_axi_bid_o), .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o),
        .s_axi_bready_i(s_axi_bready_i),
        .s_axi_arid_i(s_axi_arid_i), .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arlen_i(s_axi_arlen_i),
        .s_axi_arsize_i(s_axi_arsize_i), .s_axi_arburst_i(s_axi_arburst_i),
        .s_axi_arvalid_i(s_axi_arvalid_i), .s_axi_arready_o(s_axi_arready_o),
        .s_axi_rid_o(s_axi_rid_o), .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o),
        .s_axi_rlast_o(s_axi_rlast_o), .s_axi_rvalid_o(s_axi_rvalid_o), .s_axi_rready_i(s_axi_rready_i),
        .m_axil_awaddr_o(m_axil_awaddr_o), .m_axil_awprot_o(m_axil_awprot_o),
        .m_axil_awvalid_o(m_axil_awvalid_o), .m_axil_awready_i(m_axil_awready_i),
        .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
        .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i),
        .m_axil_bresp_i(m_axil_bresp_i), .m_axil_bvalid_i(m_axil_bvalid_i), .m_axil_bready_o(m_axil_bready_o),
        .m_axil_araddr_o(m_axil_araddr_o), .m_axil_arprot_o(m_axil_arprot_o),
        .m_axil_arvalid_o(m_axil_arvalid_o), .m_axil_arready_i(m_axil_arready_i),
        .m_axil_rdata_i(m_axil_rdata_i), .m_axil_rresp_i(m_axil_rresp_i),
        .m_axil_rvalid_i(m_axil_rvalid_i), .m_axil_rready_o(m_axil_rready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference address of beat 'beat' computed directly from the burst rules.
    function automatic logic [31:0] model_addr(input logic [31:0] start, input int size,
                                               input int len, input logic [1:0] burst, input int beat);
        longint st, step;
        st = longint'(start);
        step = longint'(1) << size;
        if (burst == 2'b00) return start;
`ifdef IOB_AXI2AXIL_WRAP_EN
        if (burst == 2'b10) begin
            longint bound, base;
            bound = longint'(len + 1) * step;
            base = st - (st % bound);
            return 32'(base + ((st - base + longint'(beat) * step) % bound));
        end
`endif
        return 32'(st + longint'(beat) * step);
    endfunction

    task automatic read_issue(input logic id, input logic [31:0] addr, input int len,
                              input int size, input logic [1:0] burst);
        @(negedge clk_i);
        s_axi_arid_i = id; s_axi_araddr_i = addr; s_axi_arlen_i = 8'(len);
        s_axi_arsize_i = 3'(size); s_axi_arburst_i = burst; s_axi_arvalid_i = 1'b1;
        #1 chk("ar_ready", s_axi_arready_o, 1'b1);
        @(negedge clk_i);
        s_axi_arvalid_i = 1'b0;
    endtask

    task automatic read_body(input logic id, input logic [31:0] addr, input int len, input int size,
                             input logic [1:0] burst, input int nbeats, input int rhold);
        logic [31:0] d;
        logic [1:0]  rr;
        for (int b = 0; b < nbeats; b++) begin
            int n = 0;
            while (!m_axil_arvalid_o && n < 20) begin @(negedge clk_i); n++; end
            chk("lite_ar_latency", n, 0);
            chk("lite_araddr", m_axil_araddr_o, model_addr(addr, size, len, burst, b));
            chk("arprot", m_axil_arprot_o, 3'b000);
            chk("s_rvalid_early", s_axi_rvalid_o, 1'b0);
            m_axil_arready_i = 1'b1;
            @(negedge clk_i);
            m_axil_arready_i = 1'b0;
            chk("lite_ar_drop", m_axil_arvalid_o, 1'b0);
            d = $urandom; rr = 2'($urandom_range(0, 3));
            m_axil_rdata_i = d; m_axil_rresp_i = rr; m_axil_rvalid_i = 1'b1; s_axi_rready_i = 1'b0;
            for (int h = 0; h < rhold; h++) begin
                #1 chk("rvalid_hold", s_axi_rvalid_o, 1'b1);
                chk("rdata_hold", s_axi_rdata_o, d);
                chk("lite_rready_low", m_axil_rready_o, 1'b0);
                @(negedge clk_i);
            end
            s_axi_rready_i = 1'b1;
            #1 chk("rvalid", s_axi_rvalid_o, 1'b1);
            chk("rdata", s_axi_rdata_o, d);
            chk("rresp", s_axi_rresp_o, rr);
            chk("rid", s_axi_rid_o, id);
            chk("rlast", s_axi_rlast_o, b == len);
            chk("lite_rready", m_axil_rready_o, 1'b1);
            @(negedge clk_i);
            m_axil_rvalid_i = 1'b0; s_axi_rready_i = 1'b0;
        end
        if (nbeats == len + 1) #1 chk("r_done_arready", s_axi_arready_o, 1'b1);
    endtask

    task automatic write_issue(input logic id, input logic [31:0] addr, input int len,
                               input int size, input logic [1:0] burst);
        @(negedge clk_i);
        s_axi_awid_i = id; s_axi_awaddr_i = addr; s_axi_awlen_i = 8'(len);
        s_axi_awsize_i = 3'(size); s_axi_awburst_i = burst; s_axi_awvalid_i = 1'b1;
        #1 chk("aw_ready", s_axi_awready_o, 1'b1);
        @(negedge clk_i);
        s_axi_awvalid_i = 1'b0;
    endtask

    // err_beat < 0 draws random Lite responses; otherwise only that beat returns SLVERR.
    task automatic write_body(input logic id, input logic [31:0] addr, input int len, input int size,
                              input logic [1:0] burst, input int err_beat, input int bhold);
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [1:0]  br, acc;
        int split;
        acc = 2'b00;
        for (int b = 0; b <= len; b++) begin
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            s_axi_wdata_i = wd; s_axi_wstrb_i = ws; s_axi_wlast_i = (b == len); s_axi_wvalid_i = 1'b1;
            #1 chk("w_ready", s_axi_wready_o, 1'b1);
            @(negedge clk_i);
            s_axi_wvalid_i = 1'b0;
            #1 chk("lite_awvalid", m_axil_awvalid_o, 1'b1);
            chk("lite_wvalid", m_axil_wvalid_o, 1'b1);
            chk("lite_awaddr", m_axil_awaddr_o, model_addr(addr, size, len, burst, b));
            chk("lite_wdata", m_axil_wdata_o, wd);
            chk("lite_wstrb", m_axil_wstrb_o, ws);
            chk("awprot", m_axil_awprot_o, 3'b000);
            split = $urandom_range(0, 2);
            m_axil_awready_i = (split != 2); m_axil_wready_i = (split != 1);
            @(negedge clk_i);
            m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0;
            if (split != 0) begin
                #1 chk("lite_awvalid_split", m_axil_awvalid_o, split == 2);
                chk("lite_wvalid_split", m_axil_wvalid_o, split == 1);
                m_axil_awready_i = (split == 2); m_axil_wready_i = (split == 1);
                @(negedge clk_i);
                m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0;
            end
            #1 chk("lite_bready", m_axil_bready_o, 1'b1);
            chk("s_bvalid_early", s_axi_bvalid_o, 1'b0);
            br = (err_beat < 0) ? 2'($urandom_range(0, 3)) : ((b == err_beat) ? 2'b10 : 2'b00);
            if (br > acc) acc = br;
            m_axil_bresp_i = br; m_axil_bvalid_i = 1'b1;
            @(negedge clk_i);
            m_axil_bvalid_i = 1'b0;
        end
        for (int h = 0; h < bhold; h++) begin
            #1 chk("bvalid_hold", s_axi_bvalid_o, 1'b1);
            chk("bresp_hold", s_axi_bresp_o, acc);
            @(negedge clk_i);
        end
        s_axi_bready_i = 1'b1;
        #1 chk("bvalid", s_axi_bvalid_o, 1'b1);
        chk("bid", s_axi_bid_o, id);
        chk("bresp", s_axi_bresp_o, acc);
        @(negedge clk_i);
        s_axi_bready_i = 1'b0;
        #1 chk("b_done", s_axi_bvalid_o, 1'b0);
        chk("w_done_awready", s_axi_awready_o, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_awready"}, s_axi_awready_o, 1'b1);
        chk({tag, "_arready"}, s_axi_arready_o, 1'b1);
        chk({tag, "_valids"}, {s_axi_bvalid_o, s_axi_rvalid_o, m_axil_awvalid_o,
                               m_axil_wvalid_o, m_axil_arvalid_o, s_axi_wready_o}, 6'b0);
        chk({tag, "_regs"}, {s_axi_bresp_o, s_axi_bid_o, s_axi_rid_o}, 4'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  bt;
        int ln, sz;
        rst_i = 1'b1; cke_i = 1'b1;
        {s_axi_awid_i, s_axi_awaddr_i, s_axi_awlen_i, s_axi_awsize_i, s_axi_awburst_i, s_axi_awvalid_i} = '0;
        {s_axi_arid_i, s_axi_araddr_i, s_axi_arlen_i, s_axi_arsize_i, s_axi_arburst_i, s_axi_arvalid_i} = '0;
        {s_axi_wdata_i, s_axi_wstrb_i, s_axi_wlast_i, s_axi_wvalid_i, s_axi_bready_i, s_axi_rready_i} = '0;
        {m_axil_awready_i, m_axil_wready_i, m_axil_bresp_i, m_axil_bvalid_i, m_axil_arready_i} = '0;
        {m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i} = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1 check_idle("reset");

        // Single-beat read, then a 4-beat INCR read.
        read_issue(1'b1, 32'h100, 0, 2, 2'b01);
        read_body(1'b1, 32'h100, 0, 2, 2'b01, 1, 0);
        read_issue(1'b0, 32'h200, 3, 2, 2'b01);
        read_body(1'b0, 32'h200, 3, 2, 2'b01, 4, 1);

        // FIXED write with SLVERR on the second Lite response.
        write_issue(1'b1, 32'h300, 2, 2, 2'b00);
        write_body(1'b1, 32'h300, 2, 2, 2'b00, 1, 0);

        // WRAP read and write from 0x38.
        read_issue(1'b1, 32'h38, 3, 2, 2'b10);
        read_body(1'b1, 32'h38, 3, 2, 2'b10, 4, 0);
        write_issue(1'b0, 32'h38, 3, 2, 2'b10);
        write_body(1'b0, 32'h38, 3, 2, 2'b10, -1, 0);

        // Simultaneous AR/AW at the top of the address space with back-pressure.
        @(negedge clk_i);
        s_axi_arid_i = 1'b1; s_axi_araddr_i = 32'hFFFF_FFFC; s_axi_arlen_i = 8'd1;
        s_axi_arsize_i = 3'd2; s_axi_arburst_i = 2'b01; s_axi_arvalid_i = 1'b1;
        s_axi_awid_i = 1'b0; s_axi_awaddr_i = 32'hFFFF_FFFC; s_axi_awlen_i = 8'd1;
        s_axi_awsize_i = 3'd2; s_axi_awburst_i = 2'b01; s_axi_awvalid_i = 1'b1;
        #1 chk("dual_arready", s_axi_arready_o, 1'b1);
        chk("dual_awready", s_axi_awready_o, 1'b1);
        @(negedge clk_i);
        s_axi_arvalid_i = 1'b0; s_axi_awvalid_i = 1'b0;
        write_body(1'b0, 32'hFFFF_FFFC, 1, 2, 2'b01, -1, 5);
        chk("dual_ar_pending", m_axil_arvalid_o, 1'b1);
        read_body(1'b1, 32'hFFFF_FFFC, 1, 2, 2'b01, 2, 5);

        // Clock enable low freezes the read path despite arready.
        read_issue(1'b0, 32'h500, 0, 2, 2'b01);
        cke_i = 1'b0; m_axil_arready_i = 1'b1;
        @(negedge clk_i);
        #1 chk("cke_hold", m_axil_arvalid_o, 1'b1);
        m_axil_arready_i = 1'b0; cke_i = 1'b1;
        read_body(1'b0, 32'h500, 0, 2, 2'b01, 1, 0);

        // Reset after two beats of a four-beat read, then a clean burst.
        read_issue(1'b1, 32'h400, 3, 2, 2'b01);
        read_body(1'b1, 32'h400, 3, 2, 2'b01, 2, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 check_idle("midreset");
        read_issue(1'b0, 32'h600, 3, 2, 2'b01);
        read_body(1'b0, 32'h600, 3, 2, 2'b01, 4, 0);

        // Randomized bursts of every type.
        for (int i = 0; i < 6; i++) begin
            bt = 2'($urandom_range(0, 3));
            sz = $urandom_range(0, 2);
            ln = (bt == 2'b10) ? ((2 << $urandom_range(0, 2)) - 1) : $urandom_range(0, 5);
            a = $urandom & ~((32'd1 << sz) - 32'd1);
            read_issue(1'($urandom), a, ln, sz, bt);
            read_body(s_axi_arid_i, a, ln, sz, bt, ln + 1, $urandom_range(0, 2));
            a = $urandom & ~((32'd1 << sz) - 32'd1);
            write_issue(1'($urandom), a, ln, sz, bt);
            write_body(s_axi_awid_i, a, ln, sz, bt, -1, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
